lsu_ctrl: RTL and testbench

Load/store unit controller between the AGU command port and the data-side bus interface unit (BIU). It forwards aligned AGU commands to the BIU and tracks up to `OUTS_DEPTH` outstanding transactions in an in-order tag FIFO. When responses return, it aligns and extends load data and presents a long-pipe write-back (data, itag, error) to the commit stage.

---
 rtl/lsu_ctrl_if.sv | 72 +++++++
 rtl/lsu_ctrl.sv | 141 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_if
// Description : AGU command, BIU command/response and write-back signals of
//               the load/store unit controller, with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int ITAG_WIDTH = 4
);
    logic                  agu_cmd_valid;
    logic                  agu_cmd_ready;
    logic [ADDR_SIZE-1:0]  agu_cmd_addr;
    logic                  agu_cmd_read;
    logic [XLEN-1:0]       agu_cmd_wdata;
    logic [XLEN/8-1:0]     agu_cmd_wmask;
    logic [1:0]            agu_cmd_size;
    logic                  agu_cmd_usign;
    logic [ITAG_WIDTH-1:0] agu_cmd_itag;

    logic                  biu_cmd_valid;
    logic                  biu_cmd_ready;
    logic [ADDR_SIZE-1:0]  biu_cmd_addr;
    logic                  biu_cmd_read;
    logic [XLEN-1:0]       biu_cmd_wdata;
    logic [XLEN/8-1:0]     biu_cmd_wmask;

    logic                  biu_rsp_valid;
    logic                  biu_rsp_ready;
    logic [XLEN-1:0]       biu_rsp_rdata;
    logic                  biu_rsp_err;

    logic                  lsu_o_valid;
    logic                  lsu_o_ready;
    logic [XLEN-1:0]       lsu_o_wbck_wdat;
    logic [ITAG_WIDTH-1:0] lsu_o_wbck_itag;
    logic                  lsu_o_wbck_err;
    logic                  lsu_o_misalgn;
    logic                  lsu_idle;

    // Environment side: drives AGU commands, BIU responses and write-back ready
    modport master (
        output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata,
               agu_cmd_wmask, agu_cmd_size, agu_cmd_usign, agu_cmd_itag,
        input  agu_cmd_ready,
        input  biu_cmd_valid, biu_cmd_addr, biu_cmd_read, biu_cmd_wdata,
               biu_cmd_wmask,
        output biu_cmd_ready,
        output biu_rsp_valid, biu_rsp_rdata, biu_rsp_err,
        input  biu_rsp_ready,
        input  lsu_o_valid, lsu_o_wbck_wdat, lsu_o_wbck_itag, lsu_o_wbck_err,
               lsu_o_misalgn, lsu_idle,
        output lsu_o_ready
    );

    modport slave (
        input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata,
               agu_cmd_wmask, agu_cmd_size, agu_cmd_usign, agu_cmd_itag,
        output agu_cmd_ready,
        output biu_cmd_valid, biu_cmd_addr, biu_cmd_read, biu_cmd_wdata,
               biu_cmd_wmask,
        input  biu_cmd_ready,
        input  biu_rsp_valid, biu_rsp_rdata, biu_rsp_err,
        output biu_rsp_ready,
        output lsu_o_valid, lsu_o_wbck_wdat, lsu_o_wbck_itag, lsu_o_wbck_err,
               lsu_o_misalgn, lsu_idle,
        input  lsu_o_ready
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store controller: forwards AGU commands to the BIU, keeps
//               an in-order tag FIFO and aligns/extends load write-back data.
//               Optional misalignment checking: LSU_MISALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int XLEN       = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int ITAG_WIDTH = 4,
    parameter int OUTS_DEPTH = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    lsu_ctrl_if.slave   bus
);
    localparam int C_PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int C_CNT_W = $clog2(OUTS_DEPTH) + 1;
    localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(OUTS_DEPTH - 1);
    localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(OUTS_DEPTH);

    typedef struct packed {
        logic [ITAG_WIDTH-1:0] itag;
        logic                  read;
        logic [1:0]            size;
        logic                  usign;
        logic [1:0]            addr_lo;
        logic                  misalgn;
    } entry_t;

    entry_t               r_fifo [OUTS_DEPTH];
    logic [C_PTR_W-1:0]   r_rptr;
    logic [C_PTR_W-1:0]   r_wptr;
    logic [C_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_misalgn;
    logic                 w_push;
    logic                 w_pop;
    entry_t               w_new;
    entry_t               w_head;
    logic [XLEN-1:0]      w_sh;
    logic [XLEN-1:0]      w_ld_data;

    assign w_full  = (r_count == C_FULL_CNT);
    assign w_empty = (r_count == '0);

`ifdef LSU_MISALIGN_CHK_EN
    assign w_misalgn = ((bus.agu_cmd_size == 2'b01) & bus.agu_cmd_addr[0])
                     | ((bus.agu_cmd_size == 2'b10) & (bus.agu_cmd_addr[1:0] != 2'b00))
                     |  (bus.agu_cmd_size == 2'b11);
`else
    assign w_misalgn = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Command path
    // ------------------------------------------------------------------
    assign bus.biu_cmd_valid = ~rst & bus.agu_cmd_valid & ~w_full & ~w_misalgn;
    assign bus.agu_cmd_ready = ~rst & ~w_full & (bus.biu_cmd_ready | w_misalgn);
    assign bus.biu_cmd_addr  = bus.agu_cmd_addr;
    assign bus.biu_cmd_read  = bus.agu_cmd_read;
    assign bus.biu_cmd_wdata = bus.agu_cmd_wdata;
    assign bus.biu_cmd_wmask = bus.agu_cmd_wmask;

    assign w_push = bus.agu_cmd_valid & bus.agu_cmd_ready;

    assign w_new.itag    = bus.agu_cmd_itag;
    assign w_new.read    = bus.agu_cmd_read;
    assign w_new.size    = bus.agu_cmd_size;
    assign w_new.usign   = bus.agu_cmd_usign;
    assign w_new.addr_lo = bus.agu_cmd_addr[1:0];
    assign w_new.misalgn = w_misalgn;

    // ------------------------------------------------------------------
    // Response path; a misaligned head completes without a bus response
    // ------------------------------------------------------------------
    assign w_head = r_fifo[r_rptr];

    assign bus.lsu_o_valid   = ~rst & ~w_empty & (w_head.misalgn | bus.biu_rsp_valid);
    assign bus.biu_rsp_ready = ~rst & ~w_empty & ~w_head.misalgn & bus.lsu_o_ready;

    assign w_pop = bus.lsu_o_valid & bus.lsu_o_ready;

    assign w_sh = bus.biu_rsp_rdata >> {w_head.addr_lo, 3'b000};

    always_comb begin
        w_ld_data = w_sh;
        case (w_head.size)
            2'b00:   w_ld_data = {{(XLEN-8){~w_head.usign & w_sh[7]}},   w_sh[7:0]};
            2'b01:   w_ld_data = {{(XLEN-16){~w_head.usign & w_sh[15]}}, w_sh[15:0]};
            default: w_ld_data = w_sh;
        endcase
    end

    assign bus.lsu_o_wbck_wdat = (~w_head.read | w_head.misalgn | bus.biu_rsp_err)
                                 ? '0 : w_ld_data;
    assign bus.lsu_o_wbck_itag = w_head.itag;
    assign bus.lsu_o_wbck_err  = w_head.misalgn | bus.biu_rsp_err;

`ifdef LSU_MISALIGN_CHK_EN
    assign bus.lsu_o_misalgn = w_head.misalgn;
`else
    assign bus.lsu_o_misalgn = 1'b0;
`endif

    assign bus.lsu_idle = w_empty;

    // ------------------------------------------------------------------
    // Tag FIFO state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == C_LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == C_LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed self-checking bench for lsu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    localparam int C_XLEN  = 32;
    localparam int C_ASIZE = 32;
    localparam int C_ITAGW = 4;
    localparam int C_DEPTH = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    lsu_ctrl_if #(.XLEN(C_XLEN), .ADDR_SIZE(C_ASIZE), .ITAG_WIDTH(C_ITAGW)) bus ();

    lsu_ctrl #(
        .XLEN       (C_XLEN),
        .ADDR_SIZE  (C_ASIZE),
        .ITAG_WIDTH (C_ITAGW),
        .OUTS_DEPTH (C_DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [31:0] addr, input logic read, input logic [1:0] size,
                       input logic usign, input logic [3:0] itag);
        bus.agu_cmd_valid = 1'b1;
        bus.agu_cmd_addr  = addr;
        bus.agu_cmd_read  = read;
        bus.agu_cmd_size  = size;
        bus.agu_cmd_usign = usign;
        bus.agu_cmd_itag  = itag;
    endtask

    task automatic rsp(input logic [31:0] rdata, input logic err);
        bus.biu_rsp_valid = 1'b1;
        bus.biu_rsp_rdata = rdata;
        bus.biu_rsp_err   = err;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst                = 1'b1;
        bus.agu_cmd_valid  = 1'b1;
        bus.agu_cmd_addr   = 32'h0000_1000;
        bus.agu_cmd_read   = 1'b1;
        bus.agu_cmd_wdata  = '0;
        bus.agu_cmd_wmask  = '0;
        bus.agu_cmd_size   = 2'b10;
        bus.agu_cmd_usign  = 1'b0;
        bus.agu_cmd_itag   = '0;
        bus.biu_cmd_ready  = 1'b1;
        bus.biu_rsp_valid  = 1'b0;
        bus.biu_rsp_rdata  = '0;
        bus.biu_rsp_err    = 1'b0;
        bus.lsu_o_ready    = 1'b1;

        // Reset held two cycles with a pending command
        tick();
        check("rst_biu_cmd_valid", 32'(bus.biu_cmd_valid), 32'd0);
        check("rst_agu_cmd_ready", 32'(bus.agu_cmd_ready), 32'd0);
        check("rst_lsu_o_valid",   32'(bus.lsu_o_valid),   32'd0);
        tick();
        check("rst_idle",          32'(bus.lsu_idle),      32'd1);
        rst = 1'b0;
        bus.agu_cmd_valid = 1'b0;
        #1;
        check("post_rst_idle",     32'(bus.lsu_idle),      32'd1);

        // Signed byte load
        cmd(32'h0000_1003, 1'b1, 2'b00, 1'b0, 4'd5);
        #1;
        check("sb_biu_valid", 32'(bus.biu_cmd_valid), 32'd1);
        check("sb_biu_addr",  bus.biu_cmd_addr,       32'h0000_1003);
        tick();
        bus.agu_cmd_valid = 1'b0;
        rsp(32'h8000_0000, 1'b0);
        #1;
        check("sb_valid", 32'(bus.lsu_o_valid),     32'd1);
        check("sb_wdat",  bus.lsu_o_wbck_wdat,      32'hFFFF_FF80);
        check("sb_itag",  32'(bus.lsu_o_wbck_itag), 32'd5);
        check("sb_err",   32'(bus.lsu_o_wbck_err),  32'd0);
        check("sb_rsp_ready", 32'(bus.biu_rsp_ready), 32'd1);
        tick();
        bus.biu_rsp_valid = 1'b0;
        #1;
        check("sb_idle", 32'(bus.lsu_idle), 32'd1);

        // Unsigned half load
        cmd(32'h0000_1002, 1'b1, 2'b01, 1'b1, 4'd6);
        tick();
        bus.agu_cmd_valid = 1'b0;
        rsp(32'h8001_0000, 1'b0);
        #1;
        check("uh_wdat", bus.lsu_o_wbck_wdat,      32'h0000_8001);
        check("uh_itag", 32'(bus.lsu_o_wbck_itag), 32'd6);
        tick();
        bus.biu_rsp_valid = 1'b0;

        // Back-to-back: fill, stall, drain in order
        cmd(32'h0000_2000, 1'b1, 2'b10, 1'b0, 4'd1);
        #1;
        check("b2b_ready1", 32'(bus.agu_cmd_ready), 32'd1);
        tick();
        cmd(32'h0000_2004, 1'b1, 2'b10, 1'b0, 4'd2);
        #1;
        check("b2b_ready2", 32'(bus.agu_cmd_ready), 32'd1);
        tick();
        cmd(32'h0000_2008, 1'b1, 2'b10, 1'b0, 4'd3);
        #1;
        check("b2b_full_ready", 32'(bus.agu_cmd_ready), 32'd0);
        check("b2b_full_biu",   32'(bus.biu_cmd_valid), 32'd0);
        check("b2b_no_wb",      32'(bus.lsu_o_valid),   32'd0);
        rsp(32'h1111_1111, 1'b0);
        #1;
        check("b2b_nobypass", 32'(bus.agu_cmd_ready),   32'd0);
        check("b2b_wb1_itag", 32'(bus.lsu_o_wbck_itag), 32'd1);
        check("b2b_wb1_wdat", bus.lsu_o_wbck_wdat,      32'h1111_1111);
        tick();
        bus.biu_rsp_valid = 1'b0;
        #1;
        check("b2b_ready3", 32'(bus.agu_cmd_ready), 32'd1);
        tick();
        bus.agu_cmd_valid = 1'b0;
        rsp(32'h2222_2222, 1'b0);
        #1;
        check("b2b_wb2_itag", 32'(bus.lsu_o_wbck_itag), 32'd2);
        tick();
        rsp(32'h3333_3333, 1'b0);
        #1;
        check("b2b_wb3_itag", 32'(bus.lsu_o_wbck_itag), 32'd3);
        check("b2b_wb3_wdat", bus.lsu_o_wbck_wdat,      32'h3333_3333);
        tick();
        bus.biu_rsp_valid = 1'b0;
        #1;
        check("b2b_idle", 32'(bus.lsu_idle), 32'd1);

        // Store with back-pressure, then bus error
        cmd(32'h0000_3000, 1'b0, 2'b10, 1'b0, 4'd7);
        bus.agu_cmd_wdata = 32'hDEAD_BEEF;
        bus.agu_cmd_wmask = 4'hF;
        #1;
        check("st_biu_read",  32'(bus.biu_cmd_read),  32'd0);
        check("st_biu_wdata", bus.biu_cmd_wdata,      32'hDEAD_BEEF);
        check("st_biu_wmask", 32'(bus.biu_cmd_wmask), 32'hF);
        tick();
        bus.agu_cmd_valid = 1'b0;
        bus.lsu_o_ready   = 1'b0;
        rsp(32'hCAFE_F00D, 1'b1);
        #1;
        check("bp_rsp_ready", 32'(bus.biu_rsp_ready), 32'd0);
        check("bp_valid",     32'(bus.lsu_o_valid),   32'd1);
        tick();
        check("bp_hold", 32'(bus.lsu_idle), 32'd0);
        bus.lsu_o_ready = 1'b1;
        #1;
        check("err_flag", 32'(bus.lsu_o_wbck_err),  32'd1);
        check("err_wdat", bus.lsu_o_wbck_wdat,      32'd0);
        check("err_itag", 32'(bus.lsu_o_wbck_itag), 32'd7);
        tick();
        bus.biu_rsp_valid = 1'b0;
        bus.biu_rsp_err   = 1'b0;
        #1;
        check("err_idle", 32'(bus.lsu_idle), 32'd1);

        // Stray response while empty
        rsp(32'h1234_5678, 1'b0);
        #1;
        check("stray_rsp_ready", 32'(bus.biu_rsp_ready), 32'd0);
        check("stray_valid",     32'(bus.lsu_o_valid),   32'd0);
        tick();
        bus.biu_rsp_valid = 1'b0;

        // Misaligned word load followed by an aligned load
`ifdef LSU_MISALIGN_CHK_EN
        bus.biu_cmd_ready = 1'b0;
        cmd(32'h0000_1001, 1'b1, 2'b10, 1'b0, 4'd1);
        #1;
        check("ma_biu_valid",  32'(bus.biu_cmd_valid), 32'd0);
        check("ma_agu_ready",  32'(bus.agu_cmd_ready), 32'd1);
        check("ma_not_yet_wb", 32'(bus.lsu_o_valid),   32'd0);
        tick();
        bus.biu_cmd_ready = 1'b1;
        cmd(32'h0000_1004, 1'b1, 2'b10, 1'b0, 4'd2);
        #1;
        check("ma_b_biu_valid", 32'(bus.biu_cmd_valid),   32'd1);
        check("ma_wb_valid",    32'(bus.lsu_o_valid),     32'd1);
        check("ma_wb_itag",     32'(bus.lsu_o_wbck_itag), 32'd1);
        check("ma_wb_err",      32'(bus.lsu_o_wbck_err),  32'd1);
        check("ma_wb_misalgn",  32'(bus.lsu_o_misalgn),   32'd1);
        check("ma_wb_wdat",     bus.lsu_o_wbck_wdat,      32'd0);
        check("ma_rsp_ready",   32'(bus.biu_rsp_ready),   32'd0);
        tick();
`else
        cmd(32'h0000_1001, 1'b1, 2'b10, 1'b0, 4'd1);
        #1;
        check("ma_biu_valid", 32'(bus.biu_cmd_valid), 32'd1);
        check("ma_biu_addr",  bus.biu_cmd_addr,       32'h0000_1001);
        tick();
        cmd(32'h0000_1004, 1'b1, 2'b10, 1'b0, 4'd2);
        rsp(32'h4433_2211, 1'b0);
        #1;
        check("ma_wb_itag",    32'(bus.lsu_o_wbck_itag), 32'd1);
        check("ma_wb_err",     32'(bus.lsu_o_wbck_err),  32'd0);
        check("ma_wb_misalgn", 32'(bus.lsu_o_misalgn),   32'd0);
        check("ma_wb_wdat",    bus.lsu_o_wbck_wdat,      32'h0044_3322);
        tick();
`endif
        bus.agu_cmd_valid = 1'b0;
        rsp(32'h5566_7788, 1'b0);
        #1;
        check("ma_b_itag",    32'(bus.lsu_o_wbck_itag), 32'd2);
        check("ma_b_wdat",    bus.lsu_o_wbck_wdat,      32'h5566_7788);
        check("ma_b_err",     32'(bus.lsu_o_wbck_err),  32'd0);
        check("ma_b_misalgn", 32'(bus.lsu_o_misalgn),   32'd0);
        tick();
        bus.biu_rsp_valid = 1'b0;
        #1;
        check("final_idle", 32'(bus.lsu_idle), 32'd1);

        // Reset mid-operation discards outstanding entries
        cmd(32'h0000_4000, 1'b1, 2'b10, 1'b0, 4'd9);
        tick();
        bus.agu_cmd_valid = 1'b0;
        check("pre_rst_busy", 32'(bus.lsu_idle), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_idle", 32'(bus.lsu_idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
